// File: rtl/alu_op_issue.sv
// RV64I ALU issue stage: 2-entry skid FIFO, op decode, registered operands, branch redirect/flush.
// Acceptance to op_valid is 2 edges; op/operands hold while op_valid && !op_ready, in_ready drops on full or taken-branch flush.

// Generic synchronous FIFO: 0-cycle head visibility, push refused by caller when full.
// Flush empties it at the next edge and overrides any push/pop in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
         if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_dat = mem[rd_ptr];
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
endmodule

module alu_op_issue #(
   parameter int XLEN       = 64,
   parameter int FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   output logic            op_valid,
   input  logic            op_ready,
   output logic [3:0]      Alu_opr,
   output logic [XLEN-1:0] IP_data1,
   output logic [XLEN-1:0] IP_data2,
   input  logic            is_br_taken,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            illegal_instr
);
   localparam logic [6:0] OPC_OP  = 7'b0110011;
   localparam logic [6:0] OPC_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BR  = 7'b1100011;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
   } entry_t;

   entry_t          in_entry;
   entry_t          head;
   logic            fifo_full, fifo_empty;
   logic            fire, flush_now, load_slot, pop, load, push;
   logic            br_q;
   logic [XLEN-1:0] tgt_q;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] i_imm, b_imm, shamt;
   logic [3:0]      dec_opr;
   logic            dec_legal, dec_br;
   logic [XLEN-1:0] dec_d2;
   logic            unused_rs1_idx;

   assign in_entry = '{instr: in_instr, pc: in_pc, rs1: in_rs1, rs2: in_rs2};

   sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush_now),
      .push     (push),
      .push_dat (in_entry),
      .pop      (pop),
      .head_dat (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign opcode         = head.instr[6:0];
   assign funct3         = head.instr[14:12];
   assign funct7         = head.instr[31:25];
   assign i_imm          = {{(XLEN-12){head.instr[31]}}, head.instr[31:20]};
   assign b_imm          = {{(XLEN-13){head.instr[31]}}, head.instr[31], head.instr[7],
                            head.instr[30:25], head.instr[11:8], 1'b0};
   assign shamt          = {{(XLEN-6){1'b0}}, head.instr[25:20]};
   assign unused_rs1_idx = ^head.instr[19:15];

   always_comb begin
      dec_opr   = 4'b1111;
      dec_legal = 1'b0;
      dec_br    = 1'b0;
      dec_d2    = head.rs2;
      case (opcode)
         OPC_OP: begin
            dec_legal = 1'b1;
            case ({funct7, funct3})
               {7'h00, 3'b000}: dec_opr = 4'b0000;
               {7'h20, 3'b000}: dec_opr = 4'b0001;
               {7'h00, 3'b001}: dec_opr = 4'b0010;
               {7'h00, 3'b100}: dec_opr = 4'b0011;
               {7'h00, 3'b101}: dec_opr = 4'b0100;
               {7'h00, 3'b110}: dec_opr = 4'b0101;
               {7'h00, 3'b111}: dec_opr = 4'b0110;
               default:         dec_legal = 1'b0;
            endcase
         end
         OPC_IMM: begin
            dec_legal = 1'b1;
            dec_d2    = i_imm;
            case (funct3)
               3'b000: dec_opr = 4'b0000;
               3'b100: dec_opr = 4'b0011;
               3'b110: dec_opr = 4'b0101;
               3'b111: dec_opr = 4'b0110;
               3'b001: begin
                  dec_opr   = 4'b0010;
                  dec_d2    = shamt;
                  dec_legal = (head.instr[31:26] == 6'b0);
               end
               3'b101: begin
                  dec_opr   = 4'b0100;
                  dec_d2    = shamt;
                  dec_legal = (head.instr[31:26] == 6'b0);
               end
               default: dec_legal = 1'b0;
            endcase
         end
         OPC_BR: begin
            dec_legal = 1'b1;
            dec_br    = 1'b1;
            case (funct3)
               3'b000:  dec_opr = 4'b0111;
               3'b001:  dec_opr = 4'b1000;
               3'b100:  dec_opr = 4'b1001;
               3'b101:  dec_opr = 4'b1010;
               default: begin
                  dec_legal = 1'b0;
                  dec_br    = 1'b0;
               end
            endcase
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // A taken branch blocks the head move and any enqueue in its consume cycle.
   assign fire      = op_valid && op_ready;
   assign flush_now = fire && br_q && !is_br_taken;
   assign load_slot = !op_valid || fire;
   assign pop       = load_slot && !fifo_empty && !flush_now;
   assign load      = pop && dec_legal;
   assign in_ready  = !reset && !fifo_full && !flush_now;
   assign push      = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         op_valid       <= 1'b0;
         Alu_opr        <= 4'b1111;
         IP_data1       <= '0;
         IP_data2       <= '0;
         br_q           <= 1'b0;
         tgt_q          <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         illegal_instr  <= 1'b0;
      end else begin
         redirect_valid <= flush_now;
         illegal_instr  <= pop && !dec_legal;
         if (flush_now) redirect_pc <= tgt_q;
         if (flush_now) begin
            op_valid <= 1'b0;
            Alu_opr  <= 4'b1111;
            br_q     <= 1'b0;
         end else if (load) begin
            op_valid <= 1'b1;
            Alu_opr  <= dec_opr;
            IP_data1 <= head.rs1;
            IP_data2 <= dec_d2;
            br_q     <= dec_br;
            tgt_q    <= head.pc + b_imm;
         end else if (fire) begin
            op_valid <= 1'b0;
            Alu_opr  <= 4'b1111;
            br_q     <= 1'b0;
         end
      end
   end
endmodule

// File: doc/alu_op_issue.md
# alu_op_issue

Issue stage that feeds the 64-bit RISC-V ALU in the 2-way superscalar core. It accepts decoded-register-read instructions through a 2-entry skid FIFO, maps RV64I OP, OP-IMM and BRANCH instructions to the ALU's 4-bit operation codes, and presents registered operands. It resolves branches from the ALU's branch flag and generates a fetch redirect plus a local flush.

## Interface

Parameters:
- XLEN, 64, operand width.
- FIFO_DEPTH, 2, skid FIFO entries. Only 2 is supported.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction and operands present.
- in_ready  out  1  FIFO can accept. Equals !full && !flush_now.
- in_instr  in  32  RV64I instruction word.
- in_pc  in  64  instruction PC.
- in_rs1  in  64  rs1 register value.
- in_rs2  in  64  rs2 register value.
- op_valid  out  1  output register holds a valid op.
- op_ready  in  1  execute stage consumes the op.
- Alu_opr  out  4  ALU operation code.
- IP_data1  out  64  first operand, signed.
- IP_data2  out  64  second operand, signed.
- is_br_taken  in  1  ALU branch flag. Active-low: 0 means the branch condition is met.
- redirect_valid  out  1  one-cycle pulse: taken branch.
- redirect_pc  out  64  branch target.
- illegal_instr  out  1  one-cycle pulse: unsupported instruction dropped.

## Operation

- Opcode map, OP (0110011):
  - ADD → 0000. SUB (funct7 0100000) → 0001.
  - SLL → 0010. XOR → 0011. SRL (funct7 0000000) → 0100.
  - OR → 0101. AND → 0110.
  - IP_data1 = rs1, IP_data2 = rs2.
- Opcode map, OP-IMM (0010011):
  - ADDI → 0000, XORI → 0011, ORI → 0101, ANDI → 0110.
  - SLLI → 0010, SRLI (imm[11:6] = 0) → 0100.
  - IP_data2 = sign-extended I-immediate. For shifts, IP_data2 = zero-extended shamt[5:0].
- Opcode map, BRANCH (1100011):
  - BEQ → 0111, BNE → 1000, BLT → 1001, BGE → 1010.
  - IP_data1 = rs1, IP_data2 = rs2.
  - The block retains target = pc + sign-extended B-immediate (64-bit wrap).
- Illegal instructions: every other encoding, including SUB/SRA/SRAI variants not listed, is illegal.
  - Illegal instructions are decoded when they leave the FIFO head and are not loaded into the output register.
  - illegal_instr pulses for 1 cycle per dropped instruction.
- FIFO: 2 entries, written on in_valid && in_ready.
  - Head moves to the output register when the output register is empty or is being consumed (op_valid && op_ready) in the same cycle.
  - Simultaneous enqueue and dequeue on a full FIFO is not allowed, because in_ready is low when full.
- Branch resolution happens in the consume cycle (op_valid && op_ready) of a branch code. is_br_taken is sampled in that same cycle; the ALU is combinational.
  - is_br_taken == 0: taken. flush_now is asserted combinationally.
    - At that edge: FIFO emptied, output register invalidated, any same-cycle enqueue discarded (in_ready is already low).
    - Next cycle: redirect_valid = 1 and redirect_pc = target.
  - is_br_taken == 1: not taken. Normal flow continues; no redirect.
- For non-branch codes, is_br_taken is ignored.

## Timing

- Reset values (synchronous on reset high):
  - op_valid = 0, Alu_opr = 4'b1111, IP_data1 = IP_data2 = 0.
  - redirect_valid = 0, redirect_pc = 0, illegal_instr = 0.
  - FIFO empty. in_ready = 1 from the first cycle after reset deasserts; it is 0 while reset is high.
- Latency: an instruction accepted at edge N is in the FIFO after N and in the output register after N+1. Minimum 2 edges from acceptance to op_valid.
- Throughput: 1 op/cycle sustained with op_ready held high.
- Backpressure: op_valid, Alu_opr and the operands are held stable while op_valid && !op_ready.
- Redirect timing: redirect_valid is high exactly 1 cycle, the cycle after the consuming edge. While it is high, in_ready = 1 and the FIFO is empty.
- Illegal pulse: illegal_instr asserts the cycle after the head is discarded. The next FIFO entry may load on the following edge.
- Reset mid-operation: all in-flight entries and any pending redirect or illegal pulse are discarded. No redirect is emitted.
- When op_valid = 0, Alu_opr = 4'b1111 (ALU output is z).

## Test plan

- Reset then ADD: instr 0x002081B3, rs1 = 5, rs2 = 7.
  - After 2 edges: op_valid = 1, Alu_opr = 0000, IP_data1 = 5, IP_data2 = 7.
- ADDI sign extension: instr 0xFFF08093 (addi x1, x1, -1), rs1 = 3.
  - Alu_opr = 0000, IP_data2 = 0xFFFF_FFFF_FFFF_FFFF.
- Backpressure: 3 back-to-back XORs with op_ready = 0.
  - in_ready drops after 3 accepted (output register + 2 FIFO entries).
  - Outputs are held stable. On releasing op_ready, the ops drain 1 per cycle in order.
- Taken BEQ: pc = 0x1000, imm = +16, op consumed with is_br_taken = 0 while 2 ops are queued.
  - Next cycle: redirect_valid = 1, redirect_pc = 0x1010, queued ops gone, op_valid = 0.
- Not-taken BNE: is_br_taken = 1.
  - No redirect. The following op issues next cycle.
- Illegal (LW, 0x0000A083) followed by AND.
  - illegal_instr pulses once. The AND issues with Alu_opr = 0110, and no LW op is ever valid.
